// File: rtl/lut_pkg.sv
// Shared types and constants for the dimming-table loader.
package lut_pkg;

  localparam int         LUT_ADDR_BITS  = 9;
  localparam int         LUT_DATA_WIDTH = 8;
  localparam int         LUT_DEPTH      = 512;
  localparam int         LUT_MAX_CNT    = 512;
  localparam logic [7:0] LUT_HDR_O      = 8'hA5;
  localparam logic [7:0] LUT_HDR_A      = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_CNT_H,
    ST_CNT_L,
    ST_DATA,
    ST_CSUM
  } lut_state_e;

endpackage

// File: rtl/lut_csum.sv
// Running 8-bit packet checksum; zero reports whether sum plus the current byte wraps to 0.
module lut_csum #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         acc,
  input  logic [W-1:0] din,
  output logic         zero
);

  logic [W-1:0] sum;
  logic [W-1:0] sum_nxt;

  assign sum_nxt = sum + din;
  assign zero    = (sum_nxt == '0);

  // clr with acc seeds the sum with the header byte
  always_ff @(posedge clock or posedge reset) begin
    if (reset)    sum <= '0;
    else if (clr) sum <= acc ? din : '0;
    else if (acc) sum <= sum_nxt;
  end

endmodule

// File: rtl/lut_loader.sv
// Framed byte-stream parser that drives the write ports of the O/A dimming tables.
module lut_loader
  import lut_pkg::*;
#(
  parameter int         ADDR_BITS  = LUT_ADDR_BITS,
  parameter int         DATA_WIDTH = LUT_DATA_WIDTH,
  parameter int         TIMEOUT    = 1023,
  parameter logic [7:0] HDR_O      = LUT_HDR_O,
  parameter logic [7:0] HDR_A      = LUT_HDR_A
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [ADDR_BITS-1:0]  W_addr,
  output logic [DATA_WIDTH-1:0] I_dataO,
  output logic [DATA_WIDTH-1:0] I_dataA,
  output logic                  WEO,
  output logic                  WEA,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = ADDR_BITS + 1;

  lut_state_e           state, state_nxt;
  logic                 acc, tmo;
  logic [TW-1:0]        tcnt;
  logic [ADDR_BITS-1:0] addr;
  logic [CW-1:0]        rem;
  logic [7:0]           cnt_h;
  logic [15:0]          cnt_full;
  logic                 cnt_bad, addr_bad;
  logic                 tgt_a;
  logic                 csum_zero;
  logic                 wr, fin, fin_err;

  assign in_ready = ~reset;
  assign acc      = in_valid & in_ready;
  assign cnt_full = {cnt_h, in_data};
  assign cnt_bad  = cnt_full > 16'(LUT_MAX_CNT);
  assign addr_bad = |in_data[DATA_WIDTH-1:ADDR_BITS-8];
  assign tmo      = (state != ST_IDLE) && !acc && (tcnt == TW'(TIMEOUT - 1));

  lut_csum #(.W(DATA_WIDTH)) u_csum (
    .clock (clock),
    .reset (reset),
    .clr   (state == ST_IDLE),
    .acc   (acc),
    .din   (in_data),
    .zero  (csum_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (tmo) state_nxt = ST_IDLE;
    else if (acc) begin
      unique case (state)
        ST_IDLE:   if (in_data == HDR_O || in_data == HDR_A) state_nxt = ST_ADDR_H;
        ST_ADDR_H: state_nxt = addr_bad ? ST_IDLE : ST_ADDR_L;
        ST_ADDR_L: state_nxt = ST_CNT_H;
        ST_CNT_H:  state_nxt = ST_CNT_L;
        ST_CNT_L:  begin
          if (cnt_bad)              state_nxt = ST_IDLE;
          else if (cnt_full == '0)  state_nxt = ST_CSUM;
          else                      state_nxt = ST_DATA;
        end
        ST_DATA:   if (rem == CW'(1)) state_nxt = ST_CSUM;
        ST_CSUM:   state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wr      = 1'b0;
    fin     = 1'b0;
    fin_err = 1'b0;
    busy    = (state != ST_IDLE);
    if (tmo) begin
      fin     = 1'b1;
      fin_err = 1'b1;
    end else if (acc) begin
      unique case (state)
        ST_ADDR_H: if (addr_bad) begin fin = 1'b1; fin_err = 1'b1; end
        ST_CNT_L:  if (cnt_bad)  begin fin = 1'b1; fin_err = 1'b1; end
        ST_DATA:   wr = 1'b1;
        ST_CSUM:   begin fin = 1'b1; fin_err = ~csum_zero; end
        default:   ;
      endcase
    end
  end

  // Write port and status are registered so the store sees them one cycle after acceptance
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tcnt    <= '0;
      addr    <= '0;
      rem     <= '0;
      cnt_h   <= '0;
      tgt_a   <= 1'b0;
      W_addr  <= '0;
      I_dataO <= '0;
      WEO     <= 1'b0;
      WEA     <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      tcnt <= (state == ST_IDLE || acc) ? '0 : tcnt + 1'b1;
      if (acc) begin
        unique case (state)
          ST_IDLE:   tgt_a <= (in_data == HDR_A);
          ST_ADDR_H: addr[ADDR_BITS-1:8] <= in_data[ADDR_BITS-9:0];
          ST_ADDR_L: addr[7:0] <= in_data;
          ST_CNT_H:  cnt_h <= in_data;
          ST_CNT_L:  rem <= cnt_full[CW-1:0];
          ST_DATA:   begin
            addr <= addr + 1'b1;
            rem  <= rem - 1'b1;
          end
          default:   ;
        endcase
      end
      if (wr) begin
        W_addr  <= addr;
        I_dataO <= in_data;
      end
      WEO  <= wr & ~tgt_a;
      WEA  <= wr & tgt_a;
      done <= fin;
      if (fin) err <= fin_err;
    end
  end

  assign I_dataA = I_dataO;

endmodule

// File: doc/lut_loader.md
# lut_loader

Byte-stream loader that fills the dimming lookup tables: the write-side counterpart of the dual 512x8 ROM/RAM curve store. It parses framed packets from the host byte link and produces the store's write address, data and per-table write strobes, one entry per accepted data byte. Data arrives from a valid/ready source. Packet framing, length and checksum are checked, and completion and error status are reported per packet.

## Interface
- ADDR_BITS, 9, table address width (512 entries)
- DATA_WIDTH, 8, entry width
- TIMEOUT, 1023, idle cycles allowed between bytes inside a packet before abort
- HDR_O, 8'hA5, header selecting table O (WEO)
- HDR_A, 8'h5A, header selecting table A (WEA)

Ports:
- clock  in  1  single clock; the store's write ports must be clocked by this same clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  byte available
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts byte
- W_addr  out  9  table write address
- I_dataO  out  8  write data to table O
- I_dataA  out  8  write data to table A (same value as I_dataO)
- WEO  out  1  write strobe, table O
- WEA  out  1  write strobe, table A
- busy  out  1  packet in progress
- done  out  1  one-cycle pulse at packet end
- err  out  1  status of last packet, valid with done and held until next done

## Operation
- Packet format: HDR, ADDR_H, ADDR_L, CNT_H, CNT_L, DATA×CNT, CSUM.
- Handshake: a byte is accepted on an edge with in_valid && in_ready. in_ready=0 in reset, 1 otherwise; the loader never stalls.
- FSM states: IDLE, ADDR_H, ADDR_L, CNT_H, CNT_L, DATA, CSUM.
- IDLE: HDR_O or HDR_A latches the target and goes to ADDR_H. Any other byte is discarded silently with no done.
- ADDR_H: bit0 becomes addr[8]. Bits 7:1 must be 0, else abort.
- CNT: 16-bit count, legal range 0..512. Above 512 aborts after CNT_L. Count 0 goes directly to CSUM.
- DATA: each byte produces one write at the current address, then address+1 modulo 512 (511 wraps to 0), remaining-1. At 0 the FSM goes to CSUM.
- Checksum: 8-bit sum of all packet bytes HDR..CSUM inclusive must equal 8'h00. A mismatch gives done with err=1. Writes already issued are not undone.
- Abort cases: bad ADDR_H, bad count, or timeout. Each gives done=1, err=1, and a return to IDLE.
- Timeout: the counter clears on every accepted byte and counts in any non-IDLE state. Reaching TIMEOUT aborts.
- busy=1 in all states except IDLE.

## Timing
- Reset values: in_ready=0, W_addr=0, I_dataO=0, I_dataA=0, WEO=0, WEA=0, busy=0, done=0, err=0. The FSM resets to IDLE and all counters to 0.
- Reset mid-packet: outputs clear immediately (asynchronously). Writes already strobed remain in the table.
- Write latency: a data byte accepted at edge k gives WEx=1, W_addr and data valid for the cycle after edge k, i.e. sampled by the store at edge k+1.
- Back-to-back data bytes give back-to-back strobes.
- Exactly one of WEO/WEA can be high in a cycle, and neither is high outside data writes.
- done/err: CSUM accepted at edge k gives done high for one cycle after edge k. The FSM is in IDLE in that same cycle, and a new HDR can be accepted at edge k+1.
- Abort timing: on an abort, done is high the cycle after the offending byte or the timeout edge.
- Timeout: TIMEOUT consecutive cycles without an accepted byte while busy.

## Structure
- Shared package lut_pkg:
  - FSM state enum
  - HDR_O/HDR_A constants
  - ADDR_BITS/DATA_WIDTH and table depth 512
  - max count 512
- Sub-module lut_csum: 8-bit accumulator with clear/accumulate/zero-check.
- The FSM, address and count counters, and timeout counter stay in the top module.

## Test plan
- Load O: A5 00 10 00 03 11 22 33 CSUM (sum=0) -> WEO on three consecutive cycles at addr 0x010/0x011/0x012 with data 11/22/33; WEA never high; done=1, err=0.
- Wrap: 5A 01 FF 00 02 AA BB CSUM -> WEA writes AA@0x1FF, then BB@0x000; done, err=0.
- Bad checksum: valid A-packet, CSUM off by 1 -> all writes issued, done=1, err=1.
- Framing errors:
  - ADDR_H=0x02 -> abort, done/err=1, no writes.
  - Count 0x0201 -> abort after CNT_L.
  - Count 0 with correct CSUM -> done, err=0, no writes.
- Stall/timeout: packet paused TIMEOUT-1 cycles mid-data -> completes normally. Pause TIMEOUT cycles -> done/err=1, FSM IDLE, next packet loads correctly.
- Reset during DATA after 2 of 4 writes -> outputs 0 at once, busy=0. Garbage byte 0x00 ignored. Fresh packet loads with err=0.
